car_ctl: RTL and testbench

Per-player race controller for the drag-racing game. Turns button inputs into engine RPM, gear and car position, and runs the race state machine (idle, countdown, race, finish). It sits directly upstream of the car-drawing stage and drives its `car_xpos`/`car_ypos` inputs. It updates once per video frame, during vertical sync, so the position is stable across every active frame.

---
 rtl/drag_pkg.sv | 27 ++
 rtl/btn_edge_latch.sv | 34 +++
 rtl/car_ctl.sv | 199 +++++++++++++++++++
 tb/tb_car_ctl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drag_pkg.sv
// Shared types and constants for the drag-racing car controller.
package drag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

    localparam int RPM_STEP_UP = 6;
    localparam int RPM_STEP_DN = 3;
    localparam int RPM_MAX     = 255;
    localparam int FRAC_W      = 4;

    // One frame of engine response: rev up (saturating) or fall back (floored at 0).
    function automatic logic [7:0] rpm_rev(input logic [7:0] rpm, input logic thr);
        logic [8:0] sum;
        sum = {1'b0, rpm} + 9'(RPM_STEP_UP);
        if (thr) begin
            rpm_rev = (sum > 9'(RPM_MAX)) ? 8'(RPM_MAX) : sum[7:0];
        end else begin
            rpm_rev = (rpm < 8'(RPM_STEP_DN)) ? 8'd0 : (rpm - 8'(RPM_STEP_DN));
        end
    endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detector with a pending flag that survives until the next frame tick.
module btn_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_pending
);

    logic r_btn;
    logic r_pending;
    logic w_rise;

    assign w_rise = i_btn & ~r_btn;

    // Track the button level; a tick consumes the flag, but an edge landing on
    // the tick cycle itself is carried over to the following tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_btn <= i_btn;
            if (i_tick) begin
                r_pending <= w_rise;
            end else if (w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/car_ctl.sv
// Per-player race controller: frame-rate FSM, engine RPM, gearbox and car position.
import drag_pkg::*;

module car_ctl #(
    parameter int X_START      = 20,
    parameter int Y_START      = 600,
    parameter int X_FINISH     = 700,
    parameter int COUNT_FRAMES = 60,
    parameter int MAX_GEAR     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        throttle,
    input  logic        shift_up,
    output logic [11:0] car_xpos,
    output logic [11:0] car_ypos,
    output logic [2:0]  gear,
    output logic [7:0]  rpm,
    output logic [1:0]  countdown,
    output logic        finished
);

    localparam logic [15:0] ACC_START = 16'(X_START << FRAC_W);

    // Frame tick
    logic r_vsync;
    logic r_tick;

    // Pending button requests
    logic w_start_pend;
    logic w_shift_pend;

    // Game state
    state_t      r_state;
    logic [15:0] r_acc;
    logic [2:0]  r_gear;
    logic [7:0]  r_rpm;
    logic [1:0]  r_digit;
    logic [15:0] r_cnt;
    logic [11:0] r_xpos;
    logic [1:0]  r_countdown;
    logic        r_finished;

    // Next-state values
    state_t      w_state_next;
    logic [15:0] w_acc_next;
    logic [2:0]  w_gear_next;
    logic [7:0]  w_rpm_next;
    logic [1:0]  w_digit_next;
    logic [15:0] w_cnt_next;
    logic [11:0] w_xpos_next;
    logic [1:0]  w_countdown_next;
    logic        w_finished_next;

    logic [7:0]  w_rpm_adj;
    logic [7:0]  w_rpm_decay;
    logic [15:0] w_step;
    logic [15:0] w_acc_sum;

    btn_edge_latch u_start_latch (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (start),
        .i_tick    (r_tick),
        .o_pending (w_start_pend)
    );

    btn_edge_latch u_shift_latch (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (shift_up),
        .i_tick    (r_tick),
        .o_pending (w_shift_pend)
    );

    // Register vsync and turn its rising edge into a one-cycle frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsync <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_vsync <= vsync_in;
            r_tick  <= vsync_in & ~r_vsync;
        end
    end

    // Physics uses the registered (pre-tick) rpm and gear.
    assign w_rpm_adj   = rpm_rev(r_rpm, throttle);
    assign w_rpm_decay = rpm_rev(r_rpm, 1'b0);
    assign w_step      = 16'(r_rpm[7:4]) * 16'(r_gear);
    assign w_acc_sum   = r_acc + w_step;

    // Next-state logic: nothing moves except on a frame tick.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_gear_next  = r_gear;
        w_rpm_next   = r_rpm;
        w_digit_next = r_digit;
        w_cnt_next   = r_cnt;
        if (r_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_pend) begin
                        w_state_next = ST_COUNTDOWN;
                        w_digit_next = 2'd3;
                        w_cnt_next   = '0;
                    end
                end
                ST_COUNTDOWN: begin
                    w_rpm_next = w_rpm_adj;
                    if (r_cnt == 16'(COUNT_FRAMES - 1)) begin
                        w_cnt_next = '0;
                        if (r_digit == 2'd1) begin
                            w_state_next = ST_RACE;
                            w_digit_next = 2'd0;
                        end else begin
                            w_digit_next = r_digit - 2'd1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end
                ST_RACE: begin
                    w_acc_next = w_acc_sum;
                    w_rpm_next = w_rpm_adj;
                    if (w_shift_pend && (r_gear < 3'(MAX_GEAR))) begin
                        w_gear_next = r_gear + 3'd1;
                        w_rpm_next  = w_rpm_adj >> 1;
                    end
                    if (w_acc_sum[FRAC_W +: 12] >= 12'(X_FINISH)) begin
                        w_state_next = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    w_rpm_next = w_rpm_decay;
                    if (w_start_pend) begin
                        w_state_next = ST_IDLE;
                        w_acc_next   = ACC_START;
                        w_gear_next  = 3'd1;
                        w_rpm_next   = 8'd0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output values derived from the state being entered, so outputs stay registered.
    always_comb begin
        w_xpos_next      = w_acc_next[FRAC_W +: 12];
        w_countdown_next = 2'd0;
        w_finished_next  = 1'b0;
        if (w_state_next == ST_FINISH) begin
            w_xpos_next     = 12'(X_FINISH);
            w_finished_next = 1'b1;
        end
        if (w_state_next == ST_COUNTDOWN) begin
            w_countdown_next = w_digit_next;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= ACC_START;
            r_gear      <= 3'd1;
            r_rpm       <= 8'd0;
            r_digit     <= 2'd0;
            r_cnt       <= '0;
            r_xpos      <= 12'(X_START);
            r_countdown <= 2'd0;
            r_finished  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_gear      <= w_gear_next;
            r_rpm       <= w_rpm_next;
            r_digit     <= w_digit_next;
            r_cnt       <= w_cnt_next;
            r_xpos      <= w_xpos_next;
            r_countdown <= w_countdown_next;
            r_finished  <= w_finished_next;
        end
    end

    assign car_xpos  = r_xpos;
    assign car_ypos  = 12'(Y_START);
    assign gear      = r_gear;
    assign rpm       = r_rpm;
    assign countdown = r_countdown;
    assign finished  = r_finished;

endmodule

// File: tb/tb_car_ctl.sv
// Self-checking bench for car_ctl: vector table, frame-level model and scoreboard.
module tb_car_ctl;

    localparam int X_START      = 20;
    localparam int Y_START      = 600;
    localparam int X_FINISH     = 700;
    localparam int COUNT_FRAMES = 2;
    localparam int MAX_GEAR     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync_in = 1'b0;
    logic        start = 1'b0;
    logic        throttle = 1'b0;
    logic        shift_up = 1'b0;
    logic [11:0] car_xpos;
    logic [11:0] car_ypos;
    logic [2:0]  gear;
    logic [7:0]  rpm;
    logic [1:0]  countdown;
    logic        finished;

    car_ctl #(
        .X_START      (X_START),
        .Y_START      (Y_START),
        .X_FINISH     (X_FINISH),
        .COUNT_FRAMES (COUNT_FRAMES),
        .MAX_GEAR     (MAX_GEAR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync_in  (vsync_in),
        .start     (start),
        .throttle  (throttle),
        .shift_up  (shift_up),
        .car_xpos  (car_xpos),
        .car_ypos  (car_ypos),
        .gear      (gear),
        .rpm       (rpm),
        .countdown (countdown),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        int xpos;
        int gear;
        int rpm;
        int cd;
        int fin;
    } exp_t;

    typedef struct {
        bit   thr;
        bit   st;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[19];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Frame-level reference model
    int m_state, m_acc, m_gear, m_rpm, m_digit, m_cnt;
    bit m_pstart, m_pshift;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic vec_t mk(bit thr, bit st, int x, int g, int r, int cd, int fin);
        vec_t v;
        v.thr = thr; v.st = st;
        v.e.xpos = x; v.e.gear = g; v.e.rpm = r; v.e.cd = cd; v.e.fin = fin;
        return v;
    endfunction

    task automatic m_reset();
        m_state = 0; m_acc = X_START * 16; m_gear = 1; m_rpm = 0;
        m_digit = 0; m_cnt = 0; m_pstart = 0; m_pshift = 0;
    endtask

    function automatic int m_adj(int r, bit thr);
        if (thr) return (r + 6 > 255) ? 255 : r + 6;
        return (r < 3) ? 0 : r - 3;
    endfunction

    task automatic m_step(input bit thr);
        bit ps, psh;
        int r;
        ps = m_pstart; psh = m_pshift;
        m_pstart = 0; m_pshift = 0;
        case (m_state)
            0: if (ps) begin m_state = 1; m_digit = 3; m_cnt = 0; end
            1: begin
                m_rpm = m_adj(m_rpm, thr);
                if (m_cnt == COUNT_FRAMES - 1) begin
                    m_cnt = 0;
                    if (m_digit == 1) begin m_state = 2; m_digit = 0; end
                    else m_digit = m_digit - 1;
                end else m_cnt = m_cnt + 1;
            end
            2: begin
                m_acc = m_acc + (m_rpm / 16) * m_gear;
                r = m_adj(m_rpm, thr);
                if (psh && m_gear < MAX_GEAR) begin m_gear = m_gear + 1; r = r / 2; end
                m_rpm = r;
                if (m_acc / 16 >= X_FINISH) m_state = 3;
            end
            default: begin
                m_rpm = m_adj(m_rpm, 1'b0);
                if (ps) begin m_state = 0; m_acc = X_START * 16; m_gear = 1; m_rpm = 0; end
            end
        endcase
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.xpos = (m_state == 3) ? X_FINISH : m_acc / 16;
        e.gear = m_gear;
        e.rpm  = m_rpm;
        e.cd   = (m_state == 1) ? m_digit : 0;
        e.fin  = (m_state == 3) ? 1 : 0;
        return e;
    endfunction

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, ".xpos"}, int'(car_xpos), e.xpos);
            check({tag, ".ypos"}, int'(car_ypos), Y_START);
            check({tag, ".gear"}, int'(gear), e.gear);
            check({tag, ".rpm"}, int'(rpm), e.rpm);
            check({tag, ".countdown"}, int'(countdown), e.cd);
            check({tag, ".finished"}, int'(finished), e.fin);
            $display("frame %-14s x=%0d gear=%0d rpm=%0d cd=%0d fin=%0d", tag,
                     car_xpos, gear, rpm, countdown, finished);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".xpos"}, int'(car_xpos), X_START);
        check({tag, ".ypos"}, int'(car_ypos), Y_START);
        check({tag, ".gear"}, int'(gear), 1);
        check({tag, ".rpm"}, int'(rpm), 0);
        check({tag, ".countdown"}, int'(countdown), 0);
        check({tag, ".finished"}, int'(finished), 0);
    endtask

    // One video frame: optional button pulses, vsync rise, compare 2 clk later.
    task automatic run_frame(input bit thr, input bit st, input bit sh, input bit sh_late,
                             input bit use_tab, input exp_t tab, input string tag);
        exp_t e;
        @(negedge clk);
        throttle = thr;
        if (st) begin
            start = 1'b1; @(negedge clk); start = 1'b0; m_pstart = 1'b1;
        end
        if (sh && !sh_late) begin
            shift_up = 1'b1; @(negedge clk); shift_up = 1'b0; m_pshift = 1'b1;
        end
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);               // tick cycle inside the DUT
        if (sh_late) shift_up = 1'b1;
        m_step(thr);
        if (sh_late) m_pshift = 1'b1;
        if (use_tab) e = tab;
        else e = model_exp();
        sb.push_back(e);
        @(negedge clk);               // outputs updated
        shift_up = 1'b0;
        compare_front(tag);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t dummy;
        int   guard;
        int   x0;
        dummy = model_exp();

        for (int i = 0; i < 10; i++) vt[i] = mk(0, 0, 20, 1, 0, 0, 0);
        vt[10] = mk(1, 1, 20, 1, 0,  3, 0);
        vt[11] = mk(1, 0, 20, 1, 6,  3, 0);
        vt[12] = mk(1, 0, 20, 1, 12, 2, 0);
        vt[13] = mk(1, 0, 20, 1, 18, 2, 0);
        vt[14] = mk(1, 0, 20, 1, 24, 1, 0);
        vt[15] = mk(1, 0, 20, 1, 30, 1, 0);
        vt[16] = mk(1, 0, 20, 1, 36, 0, 0);
        vt[17] = mk(1, 0, 20, 1, 42, 0, 0);
        vt[18] = mk(1, 1, 20, 1, 48, 0, 0);   // start during RACE is ignored

        m_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        reset = 1'b1;

        for (int i = 0; i < 19; i++)
            run_frame(vt[i].thr, vt[i].st, 1'b0, 1'b0, 1'b1, vt[i].e, $sformatf("vec%0d", i));

        // Accelerate to rpm 240, then one more frame and on to saturation
        guard = 0;
        while (m_rpm != 240 && guard < 60) begin
            run_frame(1, 0, 0, 0, 0, dummy, "accel"); guard++;
        end
        check("accel_rpm240", int'(rpm), 240);
        x0 = m_acc / 16;
        run_frame(1, 0, 0, 0, 0, dummy, "accel246");
        check("accel_rpm246", int'(rpm), 246);
        check("accel_xstep", int'((int'(car_xpos) - x0) inside {0, 1}), 1);
        repeat (3) run_frame(1, 0, 0, 0, 0, dummy, "accel_sat");
        check("rpm_sat", int'(rpm), 255);

        // Coast down to 201, then upshift with throttle low: (201-3)>>1 = 99
        guard = 0;
        while (m_rpm != 201 && guard < 60) begin
            run_frame(0, 0, 0, 0, 0, dummy, "coast"); guard++;
        end
        run_frame(0, 0, 1, 0, 0, dummy, "shift1");
        check("shift1_gear", int'(gear), 2);
        check("shift1_rpm", int'(rpm), 99);

        // Shift edge on the tick cycle is deferred by one frame
        run_frame(0, 0, 1, 1, 0, dummy, "shift_late");
        check("shift_late_gear", int'(gear), 2);
        run_frame(0, 0, 0, 0, 0, dummy, "shift_apply");
        check("shift_apply_gear", int'(gear), 3);

        repeat (4) run_frame(1, 0, 1, 0, 0, dummy, "shift_max");
        check("shift_max_gear", int'(gear), MAX_GEAR);

        // Drive to the finish line
        guard = 0;
        while (finished !== 1'b1 && guard < 400) begin
            run_frame(1, 0, 0, 0, 0, dummy, "race"); guard++;
        end
        check("finish_flag", int'(finished), 1);
        check("finish_xpos", int'(car_xpos), X_FINISH);
        repeat (3) run_frame(1, 0, 1, 0, 0, dummy, "decay");

        // Restart to IDLE
        run_frame(0, 1, 0, 0, 0, dummy, "restart");
        check("restart_xpos", int'(car_xpos), X_START);
        check("restart_gear", int'(gear), 1);
        check("restart_fin", int'(finished), 0);
        run_frame(0, 0, 1, 0, 0, dummy, "idle_shift");

        // Second race: shifts during countdown are discarded
        run_frame(1, 1, 0, 0, 0, dummy, "cd2_start");
        repeat (6) run_frame(1, 0, 1, 0, 0, dummy, "cd2");
        check("race2_rpm", int'(rpm), 36);
        check("race2_gear", int'(gear), 1);
        repeat (3) run_frame(1, 0, 0, 0, 0, dummy, "race2");

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        throttle = 1'b0;
        run_frame(0, 0, 0, 0, 0, dummy, "post_rst");

        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
